// File: rtl/sram_axi_bridge.sv
`default_nettype none
// ============================================================================
// Module   : sram_axi_bridge
// Purpose  : Bridges two sram-like ports (inst, data) onto a single AXI
//            master, one transaction outstanding at a time, data port first.
// Revision : 1.0
// ============================================================================
module sram_axi_bridge #(
  parameter logic [3:0] INST_ID = 4'd0,
  parameter logic [3:0] DATA_ID = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RADDR = 3'd1,
    S_RDATA = 3'd2,
    S_WREQ  = 3'd3,
    S_WRESP = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t      r_state;
  logic        r_src;        // 1 = data port owns the transaction
  logic        r_wr;
  logic [31:0] r_addr;
  logic [1:0]  r_size;
  logic [31:0] r_wdata;
  logic [3:0]  r_id;
  logic        r_arvalid;
  logic        r_rready;
  logic        r_awvalid;
  logic        r_wvalid;
  logic        r_bready;
  logic        r_aw_done;
  logic        r_w_done;
  logic        r_inst_ok;
  logic        r_data_ok;
  logic [31:0] r_inst_rdata;
  logic [31:0] r_data_rdata;

  logic        w_idle;
  logic        w_grant_data;
  logic        w_grant_inst;
  logic        w_sel_wr;
  logic [1:0]  w_sel_size;
  logic        w_aw_hs;
  logic        w_w_hs;
  logic        w_aw_fin;
  logic        w_w_fin;
  logic [3:0]  w_wstrb;
  logic        w_unused;

  assign w_idle       = (r_state == S_IDLE) && !rst;
  assign w_grant_data = w_idle && data_req;
  assign w_grant_inst = w_idle && inst_req && !data_req;
  assign w_sel_wr     = w_grant_data ? data_wr   : inst_wr;
  assign w_sel_size   = w_grant_data ? data_size : inst_size;

  assign w_aw_hs  = r_awvalid && awready;
  assign w_w_hs   = r_wvalid && wready;
  assign w_aw_fin = r_aw_done || w_aw_hs;
  assign w_w_fin  = r_w_done || w_w_hs;

  always_comb begin
    w_wstrb = 4'b1111;
    case (r_size)
      2'b00:   w_wstrb = 4'b0001 << r_addr[1:0];
      2'b01:   w_wstrb = 4'b0011 << {r_addr[1], 1'b0};
      default: w_wstrb = 4'b1111;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_src        <= 1'b0;
      r_wr         <= 1'b0;
      r_addr       <= 32'd0;
      r_size       <= 2'd0;
      r_wdata      <= 32'd0;
      r_id         <= 4'd0;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_bready     <= 1'b0;
      r_aw_done    <= 1'b0;
      r_w_done     <= 1'b0;
      r_inst_ok    <= 1'b0;
      r_data_ok    <= 1'b0;
      r_inst_rdata <= 32'd0;
      r_data_rdata <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_data || w_grant_inst) begin
            r_src   <= w_grant_data;
            r_wr    <= w_sel_wr;
            r_addr  <= w_grant_data ? data_addr  : inst_addr;
            r_wdata <= w_grant_data ? data_wdata : inst_wdata;
            r_id    <= w_grant_data ? DATA_ID    : INST_ID;
            r_size  <= (w_sel_size == 2'b11) ? 2'b10 : w_sel_size;
            if (w_sel_wr) begin
              r_state   <= S_WREQ;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_aw_done <= 1'b0;
              r_w_done  <= 1'b0;
            end else begin
              r_state   <= S_RADDR;
              r_arvalid <= 1'b1;
            end
          end
        end
        S_RADDR: begin
          if (arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= S_RDATA;
          end
        end
        S_RDATA: begin
          if (rvalid && rlast) begin
            r_rready <= 1'b0;
            if (r_src) r_data_rdata <= rdata;
            else       r_inst_rdata <= rdata;
            r_data_ok <= r_src;
            r_inst_ok <= !r_src;
            r_state   <= S_DONE;
          end
        end
        S_WREQ: begin
          if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (w_w_hs) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          // Both channels may finish on the same edge; leave only then.
          if (w_aw_fin && w_w_fin) begin
            r_state   <= S_WRESP;
            r_bready  <= 1'b1;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
          end
        end
        S_WRESP: begin
          if (bvalid) begin
            r_bready  <= 1'b0;
            r_data_ok <= r_src;
            r_inst_ok <= !r_src;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          r_data_ok <= 1'b0;
          r_inst_ok <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign inst_addr_ok = w_grant_inst;
  assign data_addr_ok = w_grant_data;
  assign inst_data_ok = r_inst_ok;
  assign data_data_ok = r_data_ok;
  assign inst_rdata   = r_inst_rdata;
  assign data_rdata   = r_data_rdata;

  assign arid    = r_id;
  assign araddr  = r_addr;
  assign arsize  = {1'b0, r_size};
  assign arvalid = r_arvalid;
  assign rready  = r_rready;

  assign awid    = r_id;
  assign awaddr  = r_addr;
  assign awsize  = {1'b0, r_size};
  assign awvalid = r_awvalid;
  assign wid     = r_id;
  assign wdata   = r_wdata;
  assign wstrb   = w_wstrb;
  assign wlast   = 1'b1;
  assign wvalid  = r_wvalid;
  assign bready  = r_bready;

  // Response IDs and status codes carry no information for this bridge.
  assign w_unused = ^{rid, rresp, bid, bresp, r_wr};

endmodule
`default_nettype wire

// File: doc/sram_axi_bridge.md
SRAM_AXI_BRIDGE -- requirements
Module: sram_axi_bridge

Interface
REQ-001 Parameter: INST_ID, default 4'd0, AXI ID used for inst-port transactions.
REQ-002 Parameter: DATA_ID, default 4'd1, AXI ID used for data-port transactions.
REQ-003 Port list, one per line, as `name  direction  width  meaning`:
- clk  in  1  single clock; all logic rising-edge.
- rst  in  1  reset, synchronous, active-high.
- inst_req / data_req  in  1  sram-like request, held until addr_ok.
- inst_wr / data_wr  in  1  1 = write.
- inst_size / data_size  in  2  00 byte, 01 half, 10 word.
- inst_addr / data_addr  in  32  byte address.
- inst_wdata / data_wdata  in  32  write data, lane-aligned.
- inst_addr_ok / data_addr_ok  out  1  request accepted this cycle.
- inst_data_ok / data_data_ok  out  1  one-cycle completion pulse.
- inst_rdata / data_rdata  out  32  read data, valid with data_ok.
- arid, araddr, arsize, arvalid  out  4/32/3/1  AXI read address.
- arready  in  1  AXI read address ready.
- rid, rdata, rresp, rlast, rvalid  in  4/32/2/1/1  AXI read data.
- rready  out  1  AXI read data ready.
- awid, awaddr, awsize, awvalid  out  4/32/3/1  AXI write address.
- awready  in  1  AXI write address ready.
- wid, wdata, wstrb, wlast, wvalid  out  4/32/4/1/1  AXI write data.
- wready  in  1  AXI write data ready.
- bid, bresp, bvalid  in  4/2/1  AXI write response.
- bready  out  1  AXI write response ready.

Function
REQ-004 States: IDLE, RADDR, RDATA, WREQ, WRESP, DONE; one AXI transaction outstanding at a time.
REQ-005 IDLE grant:
- data_req has priority over inst_req.
- Grant asserts the granted port's addr_ok combinationally in the same cycle.
- The other port's addr_ok is 0.
REQ-006 On grant, the following are registered: addr, size, wdata, wr, source, id.
- size 2'b11 is registered as 2'b10.
- Next state is RADDR (wr=0) or WREQ (wr=1).
REQ-007 addr_ok is 0 in every state other than IDLE.
REQ-008 RADDR:
- arvalid=1, araddr=latched addr, arsize={1'b0,size}, arid=latched id.
- On arvalid&arready, go to RDATA.
REQ-009 RDATA:
- rready=1.
- On rvalid&rlast, register rdata and go to DONE.
- rid and rresp are ignored.
REQ-010 WREQ: awvalid and wvalid are both asserted from the first WREQ cycle; wlast=1; wid=awid=latched id.
REQ-011 WREQ completion tracking:
- aw_done and w_done are tracked separately.
- Each valid drops after its own handshake.
- Go to WRESP on the cycle both are done, including a simultaneous handshake.
REQ-012 wstrb:
- byte: 4'b0001<<addr[1:0].
- half: 4'b0011<<{addr[1],1'b0}.
- word: 4'b1111.
- wdata is passed unmodified.
REQ-013 WRESP:
- bready=1.
- On bvalid, go to DONE.
- bresp is ignored.
REQ-014 DONE:
- Assert data_ok of the latched source for exactly one cycle; the other port's data_ok is 0.
- Source rdata holds the registered read data (writes: unchanged).
- Go to IDLE.
REQ-015 Read data stays stable on inst_rdata/data_rdata until that port's next read completes.
REQ-016 Minimum latency, read: grant cycle T → arvalid T+1 → (arready T+1) → rready T+2 → (rvalid T+2) → data_ok T+3.
REQ-017 Minimum latency, write: grant T → aw/wvalid T+1 → bready T+2 → data_ok T+3.
REQ-018 A new request may be granted in the IDLE cycle following DONE; back-to-back completions are therefore ≥4 cycles apart.
REQ-019 Requests arriving while not IDLE are held off (addr_ok=0) and are not dropped.

Reset
REQ-020 While rst=1, on the next clk:
- State goes to IDLE.
- All valid/ready/addr_ok/data_ok outputs go to 0.
- rdata registers and latched fields go to 0.
- aw_done and w_done go to 0.
REQ-021 Reset mid-transaction abandons the transaction; no data_ok is generated for it.

Verification
REQ-022 The bench shall cover these directed scenarios:
- Data read word 0x1000, arready/rvalid immediate, rdata=0xDEADBEEF → data_addr_ok at T, data_data_ok at T+3, data_rdata=0xDEADBEEF.
- inst_req and data_req in same cycle → data_addr_ok=1, inst_addr_ok=0; inst granted in IDLE after data DONE, arid=INST_ID.
- Data byte write addr 0x2003, wdata=0xAB000000 → wstrb=4'b1000, awsize=3'b000, awid=DATA_ID, single data_data_ok pulse.
- Write with awready 3 cycles before wready → awvalid drops after its handshake, wvalid held; WRESP only after both done.
- Half write addr 0x2002 with bvalid delayed 5 cycles → wstrb=4'b1100, bready held high, data_ok 1 cycle after bvalid.
- rst asserted during RDATA → next cycle all valids/readies 0, state IDLE, no data_ok; subsequent read completes normally.
